// File: rtl/mul_sequencer.sv
// mul_sequencer: multi-cycle shift-add multiplier for the EX stage.
// It owns the multiply ALU code, stalls the front of the pipeline while it iterates,
// and presents the low WIDTH bits of the product for one cycle when done.
module mul_sequencer #(
  parameter int         WIDTH    = 32,
  parameter int         BPC      = 1,
  parameter logic [2:0] MUL_CODE = 3'b011
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             result_valid
);

  localparam int N  = WIDTH / BPC;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    count_q, count_d;
  logic             busy_q, busy_d;
  logic             req;
  logic [WIDTH-1:0] partial;

  assign req = ex_valid && (alu_ctrl == MUL_CODE) && !flush;

  // Partial product of the multiplicand with the low BPC multiplier bits, truncated to WIDTH.
  always_comb begin
    partial = '0;
    for (int i = 0; i < BPC; i++) begin
      if (mplier_q[i]) partial = partial + (mcand_q << i);
    end
  end

  // Sequencer next state: accept in IDLE, iterate N times in BUSY, one-cycle DONE.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    result_d = result_q;
    count_d  = count_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          mcand_d  = op_a;
          mplier_d = op_b;
          acc_d    = '0;
          count_d  = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (flush) begin
          // Killed instruction: abandon the operation, result stays untouched.
          state_d = IDLE;
        end else begin
          acc_d    = acc_q + partial;
          mcand_d  = mcand_q << BPC;
          mplier_d = mplier_q >> BPC;
          count_d  = count_q + CW'(1);
          if (count_q == CW'(N - 1)) begin
            result_d = acc_q + partial;
            state_d  = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == BUSY);
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      result_q <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
    end
  end

  // Stall covers the accepting cycle plus every BUSY cycle; a flush releases it at once.
  assign stall        = ((state_q == IDLE) && req) || ((state_q == BUSY) && !flush);
  assign result_valid = (state_q == DONE) && !flush;
  assign busy         = busy_q;
  assign result       = result_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Bench for mul_sequencer: directed sequence with random operands, checked against
// a plain 64-bit product and a cycle-count timing model (N = WIDTH/BPC).
module tb_mul_sequencer;

  localparam logic [2:0] MUL = 3'b011;
  localparam logic [2:0] ADD = 3'b010;
  localparam int N1 = 32;
  localparam int N4 = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic [2:0]  alu_ctrl = 3'b000;
  logic [31:0] op_a = '0, op_b = '0;
  logic        flush = 1'b0;
  logic        stall1, busy1, rv1, stall4, busy4, rv4;
  logic [31:0] res1, res4;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  mul_sequencer #(.WIDTH(32), .BPC(1), .MUL_CODE(MUL)) dut1 (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .alu_ctrl(alu_ctrl),
    .op_a(op_a), .op_b(op_b), .flush(flush),
    .stall(stall1), .busy(busy1), .result(res1), .result_valid(rv1));

  mul_sequencer #(.WIDTH(32), .BPC(4), .MUL_CODE(MUL)) dut4 (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .alu_ctrl(alu_ctrl),
    .op_a(op_a), .op_b(op_b), .flush(flush),
    .stall(stall4), .busy(busy4), .result(res4), .result_valid(rv4));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    return p[31:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input bit sel, input logic st, input logic bs, input logic rv);
    chk({tag, ".stall"}, 32'(sel ? stall4 : stall1), 32'(st));
    chk({tag, ".busy"},  32'(sel ? busy4  : busy1),  32'(bs));
    chk({tag, ".rv"},    32'(sel ? rv4    : rv1),    32'(rv));
  endtask

  // One multiply as the pipeline sees it: the instruction sits in EX for the whole stall
  // and the DONE cycle, with operands wiggling (they must be ignored after acceptance).
  task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input bit sel,
                        input int n, input string tag, output int done_cyc);
    @(negedge clk);
    ex_valid = 1'b1; alu_ctrl = MUL; op_a = a; op_b = b; flush = 1'b0;
    #1 chk_out({tag, ".T"}, sel, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      op_a = $urandom; op_b = $urandom;
      #1 chk_out({tag, ".busy_cyc"}, sel, 1'b1, 1'b1, 1'b0);
    end
    @(negedge clk);
    #1 chk_out({tag, ".done"}, sel, 1'b0, 1'b0, 1'b1);
    chk({tag, ".result"}, sel ? res4 : res1, ref_mul(a, b));
    done_cyc = cyc;
  endtask

  initial begin
    int d0, d1;
    logic [31:0] ra, rb;

    // Reset state
    #1 chk_out("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst.res1", res1, 32'h0);
    chk("rst.res4", res4, 32'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Basic and boundary products
    do_mul(32'd3, 32'd5, 1'b0, N1, "m3x5", d0);
    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, N1, "mff", d0);
    do_mul(32'hFFFF_FFFD, 32'd7, 1'b0, N1, "mneg", d0);
    for (int k = 0; k < 4; k++) begin
      ra = $urandom; rb = $urandom;
      do_mul(ra, rb, 1'b0, N1, "mrnd", d0);
    end

    // Flush in BUSY cycle 10
    @(negedge clk);
    ex_valid = 1'b1; alu_ctrl = MUL; op_a = 32'd11; op_b = 32'd13;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 10) flush = 1'b1;
    end
    #1 chk_out("flush.cyc", 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    flush = 1'b0; ex_valid = 1'b0;
    for (int i = 0; i < N1 + 3; i++) begin
      #1 chk_out("flush.after", 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
    end
    do_mul(32'd6, 32'd7, 1'b0, N1, "m6x7", d0);
    @(negedge clk); ex_valid = 1'b0;

    // Back-to-back: second request in the IDLE cycle right after DONE
    do_mul(32'd2, 32'd9, 1'b0, N1, "b2b1", d0);
    do_mul(32'd4, 32'd4, 1'b0, N1, "b2b2", d1);
    chk("b2b.gap", 32'(d1 - d0), 32'(N1 + 2));
    @(negedge clk);
    ex_valid = 1'b0;
    #1 chk_out("b2b.idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in BUSY cycle 5
    @(negedge clk);
    ex_valid = 1'b1; alu_ctrl = MUL; op_a = 32'd3; op_b = 32'd5;
    for (int i = 1; i <= 5; i++) @(negedge clk);
    #1 chk_out("arst.pre", 1'b0, 1'b1, 1'b1, 1'b0);
    #1 rst_n = 1'b0; ex_valid = 1'b0;
    #1 chk_out("arst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("arst.res", res1, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Non-multiply codes never stall or produce a result
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      ex_valid = 1'b1; op_a = $urandom; op_b = $urandom;
      alu_ctrl = (i < 4) ? ADD : 3'($urandom_range(4, 7));
      #1 chk_out("nonmul1", 1'b0, 1'b0, 1'b0, 1'b0);
      chk_out("nonmul4", 1'b1, 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk); ex_valid = 1'b0;

    // BPC=4 instance: 8 BUSY cycles, result_valid at T+9
    do_mul(32'd3, 32'd5, 1'b1, N4, "q3x5", d0);
    ra = $urandom; rb = $urandom;
    do_mul(ra, rb, 1'b1, N4, "qrnd", d0);
    do_mul(32'hFFFF_FFFD, 32'd7, 1'b1, N4, "qneg", d0);
    @(negedge clk); ex_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
